// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer: screen defaults, address width, colour type, FSM states.
// The CLEAR state exists only when FB_CLEAR_EN is defined.
package fb_pkg;

  localparam int unsigned FB_SCREEN_W = 160;
  localparam int unsigned FB_SCREEN_H = 120;
  localparam int unsigned ADDR_W      = 15;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [2:0]        colour_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
`ifdef FB_CLEAR_EN
    ,
    ST_CLEAR = 2'd3
`endif
  } fb_state_t;

  // Full-width row-major address; every operand is widened before the multiply.
  function automatic addr_t fb_addr(input logic [7:0] x, input logic [6:0] y,
                                    input int unsigned w);
    return addr_t'(y) * addr_t'(w) + addr_t'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-clock pixel store: one write port, one registered read port, read-first on collision.
module fb_ram
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = FB_SCREEN_W * FB_SCREEN_H
) (
  input  logic    clk,
  input  logic    wr_en,
  input  addr_t   wr_addr,
  input  colour_t wr_data,
  input  logic    rd_en,
  input  addr_t   rd_addr,
  output colour_t rd_data
);

  colour_t mem [DEPTH];

  // Non-blocking read and write in one block gives the old word on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/framebuffer_scan.sv
// Framebuffer with a drawing write port and a single-pass row-major raster readout.
// Optional clear engine (adds port clr and state CLEAR) is enabled by macro FB_CLEAR_EN.
//   state | meaning
//   IDLE  | waiting for scan_start (or clr)
//   SCAN  | reading one pixel per cycle, pix_* one cycle behind the counter
//   DONE  | scan_done held until scan_start drops
//   CLEAR | writing colour 0 to every address (FB_CLEAR_EN only)
module framebuffer_scan
  import fb_pkg::*;
#(
  parameter int unsigned SCREEN_W = FB_SCREEN_W,
  parameter int unsigned SCREEN_H = FB_SCREEN_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  colour_t    vga_colour,
  input  logic       vga_plot,
  input  logic       scan_start,
`ifdef FB_CLEAR_EN
  input  logic       clr,
`endif
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output colour_t    pix_colour,
  output logic       pix_valid,
  output logic       scan_done,
  output logic       oob_err
);

  localparam int unsigned DEPTH  = SCREEN_W * SCREEN_H;
  localparam logic [7:0]  X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST = 7'(SCREEN_H - 1);

  fb_state_t  state;
  logic [7:0] cnt_x;
  logic [6:0] cnt_y;
  logic       rd_last;
  logic       in_bounds;
  logic       clearing;
  logic       plot_ok;
  logic       wr_en;
  addr_t      wr_addr;
  colour_t    wr_data;
  logic       rd_en;
  addr_t      rd_addr;
  colour_t    rd_data;

  assign in_bounds = (32'(vga_x) < SCREEN_W) && (32'(vga_y) < SCREEN_H);

`ifdef FB_CLEAR_EN
  localparam addr_t A_LAST = addr_t'(DEPTH - 1);
  addr_t clr_addr;
  assign clearing = (state == ST_CLEAR);
`else
  assign clearing = 1'b0;
`endif

  assign plot_ok = vga_plot && !clearing;

  always_comb begin
    wr_en   = plot_ok && in_bounds;
    wr_addr = fb_addr(vga_x, vga_y, SCREEN_W);
    wr_data = vga_colour;
`ifdef FB_CLEAR_EN
    if (clearing) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
`endif
  end

  // rd_last marks that the final pixel has already been read; the next edge retires the scan.
  assign rd_en      = (state == ST_SCAN) && !rd_last;
  assign rd_addr    = fb_addr(cnt_x, cnt_y, SCREEN_W);
  assign pix_colour = pix_valid ? rd_data : '0;

  fb_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt_x     <= '0;
      cnt_y     <= '0;
      rd_last   <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      scan_done <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_addr  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef FB_CLEAR_EN
          if (clr) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end else
`endif
          if (scan_start) begin
            state   <= ST_SCAN;
            cnt_x   <= '0;
            cnt_y   <= '0;
            rd_last <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (!rd_last) begin
            pix_valid <= 1'b1;
            pix_x     <= cnt_x;
            pix_y     <= cnt_y;
            if (cnt_x == X_LAST) begin
              cnt_x <= '0;
              if (cnt_y == Y_LAST) rd_last <= 1'b1;
              else                 cnt_y   <= cnt_y + 7'd1;
            end else begin
              cnt_x <= cnt_x + 8'd1;
            end
          end else begin
            state     <= ST_DONE;
            rd_last   <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            scan_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!scan_start) begin
            state     <= ST_IDLE;
            scan_done <= 1'b0;
          end
        end
`ifdef FB_CLEAR_EN
        ST_CLEAR: begin
          if (clr_addr == A_LAST) state    <= ST_IDLE;
          else                    clr_addr <= clr_addr + addr_t'(1);
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      oob_err <= 1'b0;
    else if (plot_ok && !in_bounds)  oob_err <= 1'b1;
  end

endmodule
